// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder and its 4-bit ripple core.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  // One full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca4_core.sv
// Purely combinational 4-bit ripple-carry adder made of four full-adder cells.
module rca4_core
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign {c[i+1], s4[i]} = full_add(a4[i], b4[i], c[i]);
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams one nibble per cycle, LSB first, through a single rca4_core.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid must not depend on ready, and in_ready/out_valid are pure functions of state.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output nsa_state_t       dbg_state_o
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  nsa_state_t         state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NIBBLE_W-1:0] core_s;
  logic                core_c;
  logic [WIDTH-1:0]    sum_shift;
  logic                accept;
  logic                release_res;

  rca4_core u_core (
    .a4 (a_sh_q[NIBBLE_W-1:0]),
    .b4 (b_sh_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s4 (core_s),
    .co (core_c)
  );

  // New nibble enters at the top so the LSB nibble lands at bit 0 after NIBBLES shifts.
  if (NIBBLES == 1) begin : g_sum_one
    assign sum_shift = core_s;
  end else begin : g_sum_many
    assign sum_shift = {core_s, sum_q[WIDTH-1:NIBBLE_W]};
  end

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (release_res) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    dbg_state_o = state_q;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values; sum/cout are only written in RUN so they persist through IDLE.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sum_d   = sum_shift;
        carry_d = core_c;
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) cout_d = core_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): handshake timing, carries, backpressure, resets.
module tb_nibble_serial_adder;
  import nsa_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  nsa_state_t   dbg_state;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver: issue one op from IDLE with out_ready=1, report latency (edges after accept
  // until out_valid) and number of sampled cycles with in_ready low.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output logic [W-1:0] s, output logic c, output int lat, output int busy);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    lat = 0; busy = 0;
    while (!out_valid && lat < 20) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    if (!in_ready) busy++;
    s = sum; c = cout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic c; int lat, busy;
    run_op(16'h1234, 16'h4321, 1'b0, s, c, lat, busy);
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (busy !== 5) begin failures++; $display("FAIL basic_busy got=%0d exp=5", busy); end
    checks++; if (s !== 16'h5555) begin failures++; $display("FAIL basic_sum got=%h exp=5555", s); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", c); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_back_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk);
    checks++; if (sum !== 16'h5555) begin failures++; $display("FAIL idle_hold_sum got=%h exp=5555", sum); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL async_sum got=%h exp=0000", sum); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] s; logic c; int lat, busy;
    run_op(16'hFFFF, 16'h0000, 1'b1, s, c, lat, busy);
    checks++; if (s !== 16'h0000) begin failures++; $display("FAIL chain_sum got=%h exp=0000", s); end
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL chain_cout got=%b exp=1", c); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL chain_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_patterns();
    logic [W-1:0] s; logic c; int lat, busy;
    run_op(16'hDDDD, 16'hDDDD, 1'b1, s, c, lat, busy);
    checks++; if (s !== 16'hBBBB) begin failures++; $display("FAIL dd_sum got=%h exp=bbbb", s); end
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL dd_cout got=%b exp=1", c); end
    run_op(16'h8000, 16'h8000, 1'b0, s, c, lat, busy);
    checks++; if (s !== 16'h0000) begin failures++; $display("FAIL top_sum got=%h exp=0000", s); end
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL top_cout got=%b exp=1", c); end
    run_op(16'h0A5C, 16'h1234, 1'b1, s, c, lat, busy);
    checks++; if (s !== 16'h1C91) begin failures++; $display("FAIL mix_sum got=%h exp=1c91", s); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL mix_cout got=%b exp=0", c); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s; logic c; int lat, busy, n;
    @(negedge clk);
    a = 16'h00F0; b = 16'h0F0F; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", out_valid); end
    for (int k = 0; k < 3; k++) begin
      a = 16'h1111 * (k + 1); b = 16'h2222; cin = 1'b1; in_valid = (k != 1);
      @(negedge clk);
      checks++; if (sum !== 16'h1000) begin failures++; $display("FAIL bp_sum_hold%0d got=%h exp=1000", k, sum); end
      checks++; if (cout !== 1'b0) begin failures++; $display("FAIL bp_cout_hold%0d got=%b exp=0", k, cout); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", k, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid%0d got=%b exp=1", k, out_valid); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_idle got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_ov got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h1000) begin failures++; $display("FAIL bp_release_sum got=%h exp=1000", sum); end
    run_op(16'h0001, 16'h0002, 1'b0, s, c, lat, busy);
    checks++; if (s !== 16'h0003) begin failures++; $display("FAIL bp_next_sum got=%h exp=0003", s); end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic c; int lat, busy, seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_output got=%0d exp=0", seen); end
    run_op(16'h000F, 16'h0001, 1'b0, s, c, lat, busy);
    checks++; if (s !== 16'h0010) begin failures++; $display("FAIL midrst_next_sum got=%h exp=0010", s); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL midrst_next_cout got=%b exp=0", c); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_async_reset();
    test_carry_chain();
    test_patterns();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Nibble-serial wide adder. Accepts one WIDTH-bit operand pair plus carry-in over a valid/ready handshake. Computes the sum by pushing one 4-bit slice per cycle through a single 4-bit ripple-carry core, least significant nibble first, with the carry held in a register between slices. Sits directly upstream of the 4-bit ripple-carry adder: it sequences operands into it and collects SUM/CARRY, trading area for WIDTH/4 cycles of latency.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived local constant: number of RUN cycles per operation

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair and cin valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result a+b+cin mod 2^WIDTH
cout  output  1  carry out of the top nibble

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; internal operand shifters, carry register and nibble counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: capture a, b into shift registers; carry_reg<=cin; cnt<=0; go to RUN.
  - Inputs are ignored after capture.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the core adds a_sh[3:0] + b_sh[3:0] + carry_reg.
  - Core s4 shifts into sum from the top (sum <= {s4, sum[WIDTH-1:4]}).
  - carry_reg <= c4; a_sh, b_sh shift right by 4; cnt++.
  - On the edge where cnt==NIBBLES-1: cout <= c4; go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable; in_ready=0.
  - On out_valid&&out_ready: go to IDLE.
  - in_valid in DONE is ignored, so no same-cycle back-to-back accept. Peak rate is one op per NIBBLES+2 cycles.
- Latency: acceptance edge E0; out_valid is high after edge E0+NIBBLES. For WIDTH=4 this is 1 RUN cycle.
- sum/cout retain the last result through IDLE until the next op overwrites them. out_valid is the only qualifier.
- Overflow wraps mod 2^WIDTH; cout carries the bit-WIDTH result.
- cnt width = clog2(NIBBLES), minimum 1 bit.
- rst_n asserted mid-RUN or mid-DONE: immediate return to the reset values; the partial result is discarded and not output.
- out_ready high while not in DONE has no effect.

Decomposition:
- Package nsa_pkg:
  - NIBBLE_W=4.
  - State enum typedef nsa_state_t {IDLE, RUN, DONE}, 2-bit encoding.
- Sub-module rca4_core: purely combinational 4-bit ripple-carry adder built from four full-adder cells; ports a4, b4, ci, s4, co.
- Top: FSM, counter, shift registers, carry register.

Test Plan:
1. rst_n low 2 cycles then high -> in_ready=1, out_valid=0, sum=0x0000, cout=0. Reset asserted asynchronously mid-cycle clears outputs without a clock edge.
2. WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid rises exactly 4 cycles after accept, sum=0x5555, cout=0; in_ready low for 5 cycles total.
3. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry ripples through every nibble via carry_reg).
4. a=0xDDDD, b=0xDDDD, cin=1 -> sum=0xBBBB, cout=1. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
5. Backpressure: result ready, out_ready=0 for 3 cycles while in_valid toggles with new operands -> sum/cout stable, in_ready=0, no new capture. out_ready=1 -> IDLE next cycle, next op accepted.
6. rst_n pulsed low during the 2nd RUN cycle of 0x1234+0x4321 -> IDLE, outputs zero, out_valid never asserts. A following op 0x000F+0x0001, cin=0 yields sum=0x0010, cout=0.
